adder_tree_operand_loader: RTL and testbench
============================================

# adder_tree_operand_loader

Upstream feeder for the 8-input, 14-bit adder tree. Accepts a serial stream of operand words over a valid/ready handshake and gathers each group of 8 into a fill bank. Each completed group moves to an output bank, which presents all 8 lanes in parallel to the tree's input registers. The double bank (fill/output) sustains one word per cycle with no bubbles while the output side is drained.

## Interface
- `ADDER_WIDTH`, default 14: operand width in bits.
- `LANES`, default 8: words per group; must be a power of two.
- `clk` in 1: the single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `in_data` in ADDER_WIDTH: operand word.
- `in_valid` in 1: `in_data` is valid this cycle.
- `in_ready` out 1: loader accepts this cycle. A word transfers when `in_valid && in_ready`.
- `out_lanes` out LANES*ADDER_WIDTH: lane k occupies bits [k*ADDER_WIDTH +: ADDER_WIDTH]. Lane 0 is the first word of the group. Lanes 0..7 map to tree inputs isum0_0_0_0 … isum0_1_1_1 in binary order.
- `out_valid` out 1: `out_lanes` holds a complete group.
- `out_ready` in 1: consumer takes the group this cycle.
- `group_count` out 16: number of groups handed to the output bank, modulo 2^16.

## Operation
- State:
  - fill bank `fill[0..LANES-1]`
  - write index `wr_idx` (log2(LANES) bits)
  - flag `fill_full`
  - output bank `out[0..LANES-1]`
  - flag `out_valid`
  - `group_count`
- `out_free = !out_valid || out_ready`.
- `xfer = fill_full && out_free`.
- `in_ready = !fill_full || xfer`. This is combinational, with a path from `out_ready` to `in_ready`.
- Accept (`in_valid && in_ready`):
  - `fill[wr_idx] <= in_data`.
  - If `wr_idx == LANES-1`: `wr_idx <= 0`, `fill_full <= 1`. Otherwise `wr_idx <= wr_idx+1`.
- Transfer (`xfer`):
  - `out <= fill` (pre-edge values), `out_valid <= 1`.
  - `group_count <= group_count+1`, wrapping 0xFFFF→0.
  - `fill_full <= 0` unless the same cycle's accept sets it again. This is impossible for LANES>1, because an accept during `xfer` writes index 0.
- Drain: if `out_valid && out_ready && !xfer`, then `out_valid <= 0`. `out` keeps its last value.
- Simultaneous accept and transfer: the accepted word goes into `fill[0]`, and the transfer copies the old bank. No data is lost or duplicated.
- `out_lanes`, `out_valid` and `group_count` are driven directly from registers.
- Arithmetic: none. Words pass through bit-exact, and no sign or width extension is applied.

## Timing
- Reset values:
  - `fill`, `out`, `wr_idx`, `group_count` = 0
  - `fill_full` = 0, `out_valid` = 0
  - hence `out_lanes` = 0 and `in_ready` = 1 in the first cycle after reset
- Reset mid-group discards any partial fill and any pending output group. No group is emitted.
- Latency: the last word of a group is accepted in cycle T; `fill_full` = 1 in T+1; `xfer` in T+1 when the output side is free; `out_valid` = 1 in T+2.
- Throughput: with `out_ready` held at 1, `in_ready` stays 1 continuously, giving one group per LANES cycles.
- Backpressure:
  - Output bank full and `out_ready` = 0 → the fill bank can still complete one group. `in_ready` then drops.
  - At that point the block holds at most 2 groups.
  - `in_ready` rises in the same cycle that `out_ready` is asserted.
- `in_valid` may drop at any time mid-group. `wr_idx` holds until the next accept.

## Structure
- Shared package `adder_tree_pkg`:
  - `ADDER_WIDTH` and `LANES` constants.
  - `lane_idx_t` typedef (log2 LANES bits).
  - `LANE_LSB(k)` helper for the `out_lanes` bit mapping.
- One sub-module, `adder_tree_lane_bank`: a LANES×ADDER_WIDTH register array with an indexed write port and a parallel load port. It is instantiated twice (fill and output).
- The top level holds `wr_idx`, the flags, `group_count` and the handshake logic.

## Test plan
- Reset, then stream words 1..8 with `out_ready` = 1 → `out_valid` in cycle T+2, lane k = k+1, `group_count` = 1, `in_ready` never low.
- 24 back-to-back words (0x0000..0x0017) with `out_ready` = 1 → three groups, each one cycle wide: {0..7}, {8..15}, {16..23}. Zero input bubbles.
- `out_ready` = 0, stream 20 words → `in_ready` falls after word 16 is accepted, with group {0..7} presented and {8..15} in the fill bank. Raising `out_ready` → `in_ready` = 1 in the same cycle and groups emerge in order.
- Irregular `in_valid` (every third cycle), values 0x3FFF, 0x0000, 0x2AAA repeating → lanes match bit-exactly, with no skipped or duplicated word.
- Assert `reset` after 5 words of a group → `out_valid` = 0 and `group_count` = 0. The next 8 words form a group containing only post-reset data.
- Force `group_count` to 0xFFFF via 65535 groups (or a backdoor preload), then emit one more → `group_count` = 0x0000.

Source files
------------

// File: rtl/adder_tree_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adder_tree_pkg
// Brief    : Shared constants, lane index type and lane bit-mapping helper
//            for the adder-tree operand loader.
// Revision : 1.0 - initial release
// ============================================================================
package adder_tree_pkg;

  localparam int ADDER_WIDTH = 14;
  localparam int LANES       = 8;
  localparam int LANE_IDX_W  = $clog2(LANES);

  typedef logic [LANE_IDX_W-1:0] lane_idx_t;

  // LSB position of lane k inside a flattened lane vector.
  function automatic int LANE_LSB(input int k, input int width = ADDER_WIDTH);
    return k * width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/adder_tree_lane_bank.sv
`default_nettype none
// ============================================================================
// Module   : adder_tree_lane_bank
// Brief    : LANES x WIDTH register array with one indexed write port and a
//            parallel load port; contents presented as a flat lane vector.
// Revision : 1.0 - initial release
// ============================================================================
module adder_tree_lane_bank
  import adder_tree_pkg::*;
#(
  parameter int WIDTH  = ADDER_WIDTH,
  parameter int LANES  = adder_tree_pkg::LANES,
  parameter int IDX_W  = $clog2(LANES)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [IDX_W-1:0]       wr_idx,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   ld_en,
  input  logic [LANES*WIDTH-1:0] ld_data,
  output logic [LANES*WIDTH-1:0] q
);

  logic [WIDTH-1:0] bank_q [LANES];
  logic [WIDTH-1:0] bank_d [LANES];

  // Next contents: a parallel load replaces all lanes, an indexed write
  // then updates a single lane (the two ports are never both used on one
  // instance, so their ordering carries no meaning).
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      bank_d[k] = bank_q[k];
    end
    if (ld_en) begin
      for (int k = 0; k < LANES; k++) begin
        bank_d[k] = ld_data[LANE_LSB(k, WIDTH) +: WIDTH];
      end
    end
    if (wr_en) begin
      bank_d[wr_idx] = wr_data;
    end
  end

  // Lane storage registers, cleared on reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < LANES; k++) begin
      if (reset) begin
        bank_q[k] <= '0;
      end else begin
        bank_q[k] <= bank_d[k];
      end
    end
  end

  generate
    for (genvar k = 0; k < LANES; k++) begin : g_lane_out
      assign q[LANE_LSB(k, WIDTH) +: WIDTH] = bank_q[k];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/adder_tree_operand_loader.sv
`default_nettype none
// ============================================================================
// Module   : adder_tree_operand_loader
// Brief    : Gathers a serial valid/ready word stream into groups of LANES
//            words using a fill bank and an output bank, presenting each
//            complete group in parallel to the adder tree.
// Revision : 1.0 - initial release
// ============================================================================
module adder_tree_operand_loader
  import adder_tree_pkg::*;
#(
  parameter int ADDER_WIDTH = adder_tree_pkg::ADDER_WIDTH,
  parameter int LANES       = adder_tree_pkg::LANES
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ADDER_WIDTH-1:0]       in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [LANES*ADDER_WIDTH-1:0] out_lanes,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [15:0]                  group_count
);

  localparam int IDX_W = $clog2(LANES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic             fill_full_q, fill_full_d;
  logic             out_valid_q, out_valid_d;
  logic [15:0]      group_count_q, group_count_d;

  logic                         out_free;
  logic                         xfer;
  logic                         accept;
  logic [LANES*ADDER_WIDTH-1:0] fill_lanes;

  // Handshake: the output bank is free when empty or being drained this
  // cycle; a full fill bank accepts again in the cycle it moves out, which
  // gives the out_ready -> in_ready combinational path.
  always_comb begin
    out_free = !out_valid_q || out_ready;
    xfer     = fill_full_q && out_free;
    in_ready = !fill_full_q || xfer;
    accept   = in_valid && in_ready;
  end

  // Next-state for write index, bank flags and group counter.
  always_comb begin
    wr_idx_d      = wr_idx_q;
    fill_full_d   = fill_full_q;
    out_valid_d   = out_valid_q;
    group_count_d = group_count_q;

    // A transfer empties the fill bank; an accept of the last lane refills
    // the flag afterwards. Both in one cycle cannot happen because an
    // accept during a transfer always lands in lane 0.
    if (xfer) begin
      fill_full_d   = 1'b0;
      out_valid_d   = 1'b1;
      group_count_d = group_count_q + 16'd1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      if (wr_idx_q == LAST_IDX) begin
        wr_idx_d    = '0;
        fill_full_d = 1'b1;
      end else begin
        wr_idx_d = wr_idx_q + 1'b1;
      end
    end
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_idx_q      <= '0;
      fill_full_q   <= 1'b0;
      out_valid_q   <= 1'b0;
      group_count_q <= '0;
    end else begin
      wr_idx_q      <= wr_idx_d;
      fill_full_q   <= fill_full_d;
      out_valid_q   <= out_valid_d;
      group_count_q <= group_count_d;
    end
  end

  adder_tree_lane_bank #(
    .WIDTH (ADDER_WIDTH),
    .LANES (LANES),
    .IDX_W (IDX_W)
  ) u_fill_bank (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (accept),
    .wr_idx  (wr_idx_q),
    .wr_data (in_data),
    .ld_en   (1'b0),
    .ld_data ('0),
    .q       (fill_lanes)
  );

  adder_tree_lane_bank #(
    .WIDTH (ADDER_WIDTH),
    .LANES (LANES),
    .IDX_W (IDX_W)
  ) u_out_bank (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (1'b0),
    .wr_idx  ('0),
    .wr_data ('0),
    .ld_en   (xfer),
    .ld_data (fill_lanes),
    .q       (out_lanes)
  );

  assign out_valid   = out_valid_q;
  assign group_count = group_count_q;

endmodule
`default_nettype wire

// File: tb/tb_adder_tree_operand_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_tree_operand_loader
// Brief    : Self-checking bench for adder_tree_operand_loader against a
//            queue-based group model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adder_tree_operand_loader;

  localparam int W = 14;
  localparam int L = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic [W-1:0]     in_data;
  logic             in_valid;
  logic             in_ready;
  logic [L*W-1:0]   out_lanes;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      group_count;

  always #5 clk = ~clk;

  adder_tree_operand_loader #(
    .ADDER_WIDTH (W),
    .LANES       (L)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_lanes   (out_lanes),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .group_count (group_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: words gathered but not yet presented, the presented group,
  // whether it is still pending, and the number of groups presented.
  logic [W-1:0]   fillq [$];
  logic [L*W-1:0] m_out;
  logic           m_occ;
  logic [15:0]    m_gc;
  logic           last_acc;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    fillq.delete();
    m_out = '0;
    m_occ = 1'b0;
    m_gc  = 16'd0;
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, advance model.
  task automatic step(input logic v, input logic [W-1:0] d, input logic ordy);
    logic exp_rdy, acc, mv;
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    @(negedge clk);
    mv      = (fillq.size() == L) && (!m_occ || ordy);
    exp_rdy = (fillq.size() < L) || mv;
    check("in_ready",    {127'd0, in_ready},  {127'd0, exp_rdy});
    check("out_valid",   {127'd0, out_valid}, {127'd0, m_occ});
    check("out_lanes",   128'(out_lanes),     128'(m_out));
    check("group_count", 128'(group_count),   128'(m_gc));
    acc = v && exp_rdy;
    if (mv) begin
      for (int k = 0; k < L; k++) m_out[k*W +: W] = fillq[k];
      fillq.delete();
      m_occ = 1'b1;
      m_gc  = m_gc + 16'd1;
    end else if (m_occ && ordy) begin
      m_occ = 1'b0;
    end
    if (acc) fillq.push_back(d);
    last_acc = acc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
  endtask

  function automatic logic [W-1:0] word_of(input int pat, input int base, input int idx);
    logic [W-1:0] tbl [3];
    tbl[0] = 14'h3FFF;
    tbl[1] = 14'h0000;
    tbl[2] = 14'h2AAA;
    if (pat == 1) return tbl[idx % 3];
    return W'(base + idx);
  endfunction

  // Send n words; valid only on every gap-th cycle; bounded cycle budget.
  task automatic send_words(input int base, input int n, input logic ordy,
                            input int gap, input int pat);
    int idx = 0;
    int cyc = 0;
    while (idx < n && cyc < n * gap * 4 + 50) begin
      step((cyc % gap) == 0, word_of(pat, base, idx), ordy);
      if (last_acc) idx++;
      cyc++;
    end
    if (idx < n) check("send_timeout", 128'(idx), 128'(n));
  endtask

  task automatic flush(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1);
  endtask

  initial begin
    int idx;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    last_acc  = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    do_reset();

    // Reset state, then words 1..8 with the consumer always ready.
    send_words(1, 8, 1'b1, 1, 0);
    flush(3);
    check("grp1_lane7", 128'(out_lanes[7*W +: W]), 128'(14'd8));
    check("grp1_count", 128'(group_count), 128'(16'd1));

    // 24 back-to-back words.
    send_words(0, 24, 1'b1, 1, 0);
    flush(3);

    // Backpressure: 20 cycles of valid data with out_ready low.
    idx = 0;
    for (int c = 0; c < 20; c++) begin
      step(1'b1, W'(idx), 1'b0);
      if (last_acc) idx++;
    end
    check("bp_accepted", 128'(idx), 128'(16));
    check("bp_in_ready", {127'd0, in_ready}, 128'd0);
    while (idx < 20) begin
      step(1'b1, W'(idx), 1'b1);
      if (last_acc) idx++;
    end
    flush(12);

    // Irregular valid with edge-value pattern.
    send_words(0, 24, 1'b1, 3, 1);
    flush(3);

    // Reset mid-group.
    send_words(100, 5, 1'b1, 1, 0);
    do_reset();
    check("rst_out_valid", {127'd0, out_valid}, 128'd0);
    check("rst_count", 128'(group_count), 128'd0);
    send_words(200, 8, 1'b1, 1, 0);
    flush(3);
    check("rst_grp_lane0", 128'(out_lanes[0 +: W]), 128'(14'd200));

    // Counter wrap via backdoor preload.
    force dut.group_count_q = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.group_count_q;
    m_gc = 16'hFFFF;
    step(1'b0, '0, 1'b1);
    send_words(300, 8, 1'b1, 1, 0);
    flush(3);
    check("wrap_count", 128'(group_count), 128'(16'h0000));

    // Randomized traffic.
    for (int c = 0; c < 2000; c++) begin
      step(($urandom_range(0, 3) != 0), W'($urandom), ($urandom_range(0, 2) != 0));
    end
    flush(20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
